// File: rtl/serial_word_tx_if.sv
// serial_word_tx_if: word handshake and serial link bundle for serial_word_tx
interface serial_word_tx_if #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             tx_bit;
  logic             tx_frame;
  logic             tx_last;
  logic [CNT_W-1:0] frames_sent;
  modport master (
    output in_valid, in_data,
    input  in_ready, tx_bit, tx_frame, tx_last, frames_sent
  );
  modport slave (
    input  in_valid, in_data,
    output in_ready, tx_bit, tx_frame, tx_last, frames_sent
  );
endinterface

// File: rtl/serial_word_tx.sv
// serial_word_tx: LSB-first parallel-to-serial word transmitter with frame/last markers.
// Optional SERIAL_WORD_TX_PARITY_EN appends an even-parity bit as the final frame bit.
module serial_word_tx #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input logic            clk,
  input logic            rst_n,
  serial_word_tx_if.slave bus
);
`ifdef SERIAL_WORD_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int BW = $clog2(WIDTH + 2);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1 + PB);
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_sreg;
  logic [BW-1:0]    r_cnt;
  logic             r_bit;
  logic             r_frame;
  logic             r_last;
  logic [CNT_W-1:0] r_sent;
  logic             w_accept;
  logic             w_end;
  logic             w_bit;
`ifdef SERIAL_WORD_TX_PARITY_EN
  logic             r_par;
  assign w_bit = (r_cnt == BW'(WIDTH)) ? r_par : r_sreg[0];
`else
  assign w_bit = r_sreg[0];
`endif
  assign w_accept = bus.in_valid && (r_state == IDLE);
  assign w_end    = r_cnt == LAST;
  assign bus.in_ready    = r_state == IDLE;
  assign bus.tx_bit      = r_bit & r_frame;
  assign bus.tx_frame    = r_frame;
  assign bus.tx_last     = r_last;
  assign bus.frames_sent = r_sent;
`ifdef SERIAL_WORD_TX_PARITY_EN
  // parity of the accepted word, captured alongside the shift register load
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_par <= 1'b0;
    else if (w_accept) r_par <= ^bus.in_data;
`endif
  // frame sequencer: load on accept, shift one bit per edge, one idle gap cycle, then count the frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sreg  <= '0;
      r_cnt   <= '0;
      r_bit   <= 1'b0;
      r_frame <= 1'b0;
      r_last  <= 1'b0;
      r_sent  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_bit   <= 1'b0;
          r_frame <= 1'b0;
          r_last  <= 1'b0;
          if (w_accept) begin
            r_sreg  <= bus.in_data;
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_bit   <= w_bit;
          r_frame <= 1'b1;
          r_last  <= w_end;
          r_sreg  <= r_sreg >> 1;
          r_cnt   <= r_cnt + 1'b1;
          if (w_end) r_state <= GAP;
        end
        GAP: begin
          r_bit   <= 1'b0;
          r_frame <= 1'b0;
          r_last  <= 1'b0;
          r_sent  <= r_sent + 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_word_tx.sv
// tb_serial_word_tx: scoreboard bench for serial_word_tx (WIDTH=3/CNT_W=8 and WIDTH=1/CNT_W=2 instances)
module tb_serial_word_tx;
`ifdef SERIAL_WORD_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  logic clk;
  logic rst_n;
  int total = 0;
  int bad = 0;
  logic [1:0] qa[$];
  logic [1:0] qb[$];
  int ca[$];
  int cb[$];
  int exp_a = 0;
  int exp_b = 0;
  bit pla = 0;
  bit plb = 0;
  int wt;
  serial_word_tx_if #(.WIDTH(3), .CNT_W(8)) a ();
  serial_word_tx_if #(.WIDTH(1), .CNT_W(2)) b ();
  serial_word_tx #(.WIDTH(3), .CNT_W(8)) u_a (.clk(clk), .rst_n(rst_n), .bus(a));
  serial_word_tx #(.WIDTH(1), .CNT_W(2)) u_b (.clk(clk), .rst_n(rst_n), .bus(b));
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", n, act, exp, $time);
    end
  endtask
  task automatic send_a(input logic [2:0] w, input bit hold, output int waited);
    a.in_valid = 1;
    a.in_data = w;
    waited = 0;
    while (!a.in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) begin
      chk("a_accept_timeout", waited, 0);
      a.in_valid = 0;
      return;
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) qa.push_back({w[i], (i == 2) && (PB == 0)});
    if (PB == 1) qa.push_back({^w, 1'b1});
    exp_a = (exp_a + 1) % 256;
    ca.push_back(exp_a);
    #1;
    if (!hold) a.in_valid = 0;
  endtask
  task automatic send_b(input logic w, input bit hold, output int waited);
    b.in_valid = 1;
    b.in_data = w;
    waited = 0;
    while (!b.in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) begin
      chk("b_accept_timeout", waited, 0);
      b.in_valid = 0;
      return;
    end
    @(posedge clk);
    qb.push_back({w, PB == 0});
    if (PB == 1) qb.push_back({w, 1'b1});
    exp_b = (exp_b + 1) % 4;
    cb.push_back(exp_b);
    #1;
    if (!hold) b.in_valid = 0;
  endtask
  task automatic drain_a();
    int n = 0;
    while ((qa.size() != 0 || ca.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("a_drain_left", qa.size() + ca.size(), 0);
  endtask
  task automatic drain_b();
    int n = 0;
    while ((qb.size() != 0 || cb.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("b_drain_left", qb.size() + cb.size(), 0);
  endtask
  task automatic idle_chk();
    chk("a_idle_ready", a.in_ready, 1);
    chk("a_idle_frame", a.tx_frame, 0);
    chk("a_idle_bit", a.tx_bit, 0);
    chk("a_idle_sent", a.frames_sent, 0);
    chk("b_idle_ready", b.in_ready, 1);
    chk("b_idle_frame", b.tx_frame, 0);
    chk("b_idle_sent", b.frames_sent, 0);
  endtask
  // monitor A: pop expected bits while tx_frame is high, frame count on the gap cycle
  always @(negedge clk) begin
    logic [1:0] e;
    if (rst_n) begin
      if (a.tx_frame) begin
        if (qa.size() == 0) chk("a_extra_bit", 1, 0);
        else begin
          e = qa.pop_front();
          chk("a_bit", a.tx_bit, e[1]);
          chk("a_last", a.tx_last, e[0]);
        end
      end else begin
        chk("a_gap_bit", a.tx_bit, 0);
        chk("a_gap_last", a.tx_last, 0);
      end
      if (pla) begin
        chk("a_gap_frame", a.tx_frame, 0);
        if (ca.size() == 0) chk("a_extra_frame", 1, 0);
        else chk("a_frames_sent", a.frames_sent, ca.pop_front());
      end
      pla = a.tx_frame && a.tx_last;
    end else pla = 0;
  end
  // monitor B: same scoreboard for the single-bit instance
  always @(negedge clk) begin
    logic [1:0] e;
    if (rst_n) begin
      if (b.tx_frame) begin
        if (qb.size() == 0) chk("b_extra_bit", 1, 0);
        else begin
          e = qb.pop_front();
          chk("b_bit", b.tx_bit, e[1]);
          chk("b_last", b.tx_last, e[0]);
        end
      end else begin
        chk("b_gap_bit", b.tx_bit, 0);
        chk("b_gap_last", b.tx_last, 0);
      end
      if (plb) begin
        chk("b_gap_frame", b.tx_frame, 0);
        if (cb.size() == 0) chk("b_extra_frame", 1, 0);
        else chk("b_frames_sent", b.frames_sent, cb.pop_front());
      end
      plb = b.tx_frame && b.tx_last;
    end else plb = 0;
  end
  initial begin
    logic bw[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    a.in_valid = 0;
    a.in_data = '0;
    b.in_valid = 0;
    b.in_data = '0;
    rst_n = 1;
    #2 rst_n = 0;
    repeat (3) begin
      @(negedge clk);
      idle_chk();
    end
    rst_n = 1;
    repeat (5) begin
      @(negedge clk);
      idle_chk();
    end
    send_a(3'b110, 0, wt);
    drain_a();
    chk("single_sent", a.frames_sent, 1);
    send_a(3'b101, 1, wt);
    send_a(3'b011, 0, wt);
    chk("b2b_ready_low", wt - 1, 3 + PB + 1);
    drain_a();
    chk("b2b_sent", a.frames_sent, 3);
    send_a(3'b100, 0, wt);
    a.in_valid = 1;
    a.in_data = 3'b010;
    repeat (2) @(negedge clk);
    a.in_valid = 0;
    drain_a();
    repeat (4) @(negedge clk);
    chk("drop_valid_sent", a.frames_sent, 4);
    send_a(3'b111, 0, wt);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst_async_frame", a.tx_frame, 0);
    chk("rst_async_bit", a.tx_bit, 0);
    chk("rst_async_sent", a.frames_sent, 0);
    chk("rst_async_ready", a.in_ready, 1);
    qa.delete();
    ca.delete();
    exp_a = 0;
    exp_b = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (8) @(negedge clk);
    chk("post_rst_sent", a.frames_sent, 0);
    chk("post_rst_frame", a.tx_frame, 0);
    for (int i = 0; i < 5; i++) send_b(bw[i], i < 4, wt);
    drain_b();
    chk("wrap_sent", b.frames_sent, 1);
    drain_a();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_word_tx.md
Name: serial_word_tx

Overview:
- Parallel-to-serial transmitter. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out LSB-first, one bit per clock, on a single-bit line with frame and last markers.
- It is the sending end of the single-bit serial link used by the frontend's sequential codegen test designs. The matching deserializer consumes tx_bit/tx_frame.
- Target: lowers cleanly to llhd.entity/llhd.proc with registered signals and continuous assigns.

Parameters:
- WIDTH, 3, data bits per word (legal range 1..16).
- CNT_W, 8, width of the sent-frame counter.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  word available on in_data.
- in_ready  output  1  block can accept a word; combinational, high only in IDLE.
- in_data  input  WIDTH  word to send; sampled only on the accept edge.
- tx_bit  output  1  serial data, registered.
- tx_frame  output  1  high on every cycle that tx_bit carries a frame bit, registered.
- tx_last  output  1  high with the final bit of a frame, registered.
- frames_sent  output  CNT_W  count of completed frames; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, shift register=0, bit counter=0.
  - tx_bit=0, tx_frame=0, tx_last=0, frames_sent=0.
  - in_ready=1, because it follows state. A word is accepted only on a clock edge with rst_n high.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - in_ready=1.
  - Accept on an edge with in_valid&&in_ready: load the shift register with in_data, bit counter=0, go to SHIFT.
  - If in_valid is low, stay in IDLE; outputs hold 0.
- SHIFT:
  - On each edge, register tx_bit=sreg[0] and tx_frame=1, then shift sreg right by 1 and increment the counter.
  - tx_last=1 with the bit whose index is WIDTH-1 (the final data bit).
  - After the edge that drives that bit, go to GAP.
- Latency and frame length:
  - A word accepted on edge N presents bit 0 on tx_bit during the cycle after edge N+1, i.e. 2-edge accept-to-first-bit latency.
  - The frame occupies exactly WIDTH consecutive cycles with tx_frame high.
- GAP:
  - One cycle with tx_frame=0, tx_last=0, tx_bit=0.
  - frames_sent increments on the edge leaving GAP; go to IDLE.
- Minimum spacing: start-to-start between back-to-back words is WIDTH+2 edges. in_valid held high is honoured as soon as IDLE is re-entered.
- in_data changes while not in IDLE: ignored.
- Dropping in_valid: in_valid may drop without a transfer. Nothing is latched unless a handshake occurred.
- WIDTH=1: the single data bit is also the last bit (tx_frame and tx_last high together for 1 cycle).
- Reset mid-frame: the frame is truncated immediately. Outputs go to 0 asynchronously, frames_sent clears, and the partial word is discarded with no further bits.
- frames_sent at 2^CNT_W-1 wraps to 0 on the next completed frame.
- No X propagation: every register has a reset value, and tx_bit is forced to 0 whenever tx_frame=0.

Optional Feature:
- Macro: SERIAL_WORD_TX_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of all WIDTH data bits) is appended as an extra SHIFT cycle after bit WIDTH-1.
  - tx_last moves to the parity bit.
  - The frame is WIDTH+1 cycles; start-to-start spacing is WIDTH+3 edges.
- Undefined:
  - No parity logic is generated. Frame is WIDTH cycles, exactly as specified above.

Test Plan:
- Reset then idle:
  - Stimulus: hold rst_n=0 for 3 cycles, release, in_valid=0 for 5 cycles.
  - Required: tx_frame=0, tx_bit=0, frames_sent=0, in_ready=1 throughout.
- Single word, WIDTH=3:
  - Stimulus: in_data=3'b110 accepted.
  - Required: tx_bit sequence 0,1,1 with tx_frame=1 for 3 cycles; tx_last only on the third; one GAP cycle; frames_sent=1.
- Back-to-back:
  - Stimulus: in_valid held high with words 3'b101 then 3'b011.
  - Required: in_ready low for 4 cycles between accepts; second frame bits 1,1,0; frames_sent=2.
- Mid-frame reset:
  - Stimulus: assert rst_n=0 asynchronously after bit 1 of 3'b111.
  - Required: tx_frame drops to 0 without waiting for a clock edge; after release, no residual bits and frames_sent=0.
- Boundary WIDTH=1 and wrap:
  - Stimulus: WIDTH=1, CNT_W=2, send 5 words.
  - Required: each frame is 1 cycle with tx_last=tx_frame; frames_sent counts 1,2,3,0,1.
- Parity build (SERIAL_WORD_TX_PARITY_EN defined):
  - Stimulus: in_data=3'b110.
  - Required: tx_bit sequence 0,1,1,0; tx_last on the 4th bit; with 3'b100 the parity bit is 1.
